// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand forwarding select generator and load-use hazard detector.
// Optional macro FWD_WB2_EN: keeps the WB2 record and forwards WB-stage producers with code 3.
module fwd_sel_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_flush,
  output logic [1:0]            ex_sel_a,
  output logic [1:0]            ex_sel_b,
  output logic                  stall,
  output logic                  idex_bubble
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  mem_read;
  } rec_t;

  typedef enum logic {S_RUN = 1'b0, S_LU_STALL = 1'b1} state_t;

  rec_t   r_ex, r_mem, r_wb;
`ifdef FWD_WB2_EN
  rec_t   r_wb2;
`endif
  state_t r_state;

  logic       w_ld_hit;
  logic       w_adv;
  logic [1:0] w_sel_a, w_sel_b;

  function automatic logic f_hit(input rec_t r, input logic used, input logic [REG_ADDR_W-1:0] s);
    return used & r.valid & r.reg_write & (r.dst != '0) & (r.dst == s);
  endfunction

  // Youngest producer wins; its stage one edge later picks the mux leg.
  function automatic logic [1:0] f_sel(input rec_t ex, input rec_t mem, input rec_t wb,
                                       input logic used, input logic [REG_ADDR_W-1:0] s);
    if (f_hit(ex, used, s))       return 2'd1;
    else if (f_hit(mem, used, s)) return 2'd2;
`ifdef FWD_WB2_EN
    else if (f_hit(wb, used, s))  return 2'd3;
`else
    else if (f_hit(wb, used, s))  return 2'd0;
`endif
    else                          return 2'd0;
  endfunction

  assign w_ld_hit = r_ex.valid & r_ex.mem_read & r_ex.reg_write & (r_ex.dst != '0) &
                    ((id_rs_used & (id_rs == r_ex.dst)) | (id_rt_used & (id_rt == r_ex.dst)));
  // EX always holds a bubble in LU_STALL, so the state gate never masks a real hazard.
  assign stall       = id_valid & ~branch_flush & w_ld_hit & (r_state == S_RUN);
  assign idex_bubble = stall;
  assign w_adv       = id_valid & ~branch_flush & ~stall;

  assign w_sel_a = f_sel(r_ex, r_mem, r_wb, id_rs_used, id_rs);
  assign w_sel_b = f_sel(r_ex, r_mem, r_wb, id_rt_used, id_rt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
`ifdef FWD_WB2_EN
      r_wb2    <= '0;
`endif
      ex_sel_a <= 2'd0;
      ex_sel_b <= 2'd0;
      r_state  <= S_RUN;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
`ifdef FWD_WB2_EN
      r_wb2 <= r_wb;
`endif
      r_ex  <= w_adv ? rec_t'{1'b1, id_dst, id_reg_write, id_mem_read} : '0;
      if (stall || branch_flush) begin
        ex_sel_a <= 2'd0;
        ex_sel_b <= 2'd0;
      end else begin
        ex_sel_a <= w_sel_a;
        ex_sel_b <= w_sel_b;
      end
      case (r_state)
        S_RUN:      if (stall) r_state <= S_LU_STALL;
        S_LU_STALL: r_state <= S_RUN;
        default:    r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Bench for fwd_sel_ctrl: directed vector table, mid-stall reset, random run vs an age-queue model.
module tb_fwd_sel_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_reg_write = 0, id_mem_read = 0, branch_flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic [1:0] ex_sel_a, ex_sel_b;
  logic       stall, idex_bubble;

  int checks = 0, errors = 0;

`ifdef FWD_WB2_EN
  localparam int WB_CODE = 3;
`else
  localparam int WB_CODE = 0;
`endif

  fwd_sel_ctrl #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_flush(branch_flush),
    .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .stall(stall), .idex_bubble(idex_bubble)
  );

  always #5 clk = ~clk;

  // Model: list of issued instructions, newest first; index d = edges since it left ID minus one.
  typedef struct { bit v; int dst; bit rw; bit mr; } mrec_t;
  mrec_t hist[$];
  bit    prev_stall = 0;

  typedef struct {
    bit v; int rs; int rt; bit rsu; bit rtu; int dst; bit rw; bit mr; bit fl;
    bit e_stall; int e_sa; int e_sb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mrec_t z = '{0, 0, 0, 0};
    hist.delete();
    repeat (3) hist.push_back(z);
    prev_stall = 0;
  endtask

  function automatic bit produces(mrec_t r, bit used, int s);
    return used && r.v && r.rw && r.dst != 0 && r.dst == s;
  endfunction

  function automatic int model_sel(bit used, int s);
    for (int d = 0; d < 3; d++)
      if (produces(hist[d], used, s)) return (d == 2) ? WB_CODE : d + 1;
    return 0;
  endfunction

  // Drive one ID cycle from posedge+1; returns DUT observations and model predictions.
  task automatic step(input vec_t t, output bit a_stall, output bit a_bub, output int a_sa, output int a_sb,
                      output bit m_stall, output int m_sa, output int m_sb);
    mrec_t n;
    id_valid = t.v; id_rs = 5'(t.rs); id_rt = 5'(t.rt); id_rs_used = t.rsu; id_rt_used = t.rtu;
    id_dst = 5'(t.dst); id_reg_write = t.rw; id_mem_read = t.mr; branch_flush = t.fl;
    #1;
    a_stall = stall; a_bub = idex_bubble;
    m_stall = t.v && !t.fl && hist[0].v && hist[0].mr && hist[0].rw && hist[0].dst != 0 &&
              ((t.rsu && t.rs == hist[0].dst) || (t.rtu && t.rt == hist[0].dst));
    m_sa = (m_stall || t.fl) ? 0 : model_sel(t.rsu, t.rs);
    m_sb = (m_stall || t.fl) ? 0 : model_sel(t.rtu, t.rt);
    if (a_stall && prev_stall) chk("stall_back_to_back", 1, 0);
    prev_stall = a_stall;
    @(posedge clk); #1;
    a_sa = ex_sel_a; a_sb = ex_sel_b;
    n = '{t.v && !t.fl && !m_stall, t.dst, t.rw, t.mr};
    hist.push_front(n);
    void'(hist.pop_back());
  endtask

  vec_t tbl[17];
  bit   as, ab, ms;
  int   asa, asb, msa, msb;

  initial begin
    //         v  rs rt rsu rtu dst rw mr fl   stall sa sb
    tbl[0]  = '{1, 0, 0, 0, 0,  3, 1, 0, 0,   0, 0, 0};        // add $3
    tbl[1]  = '{1, 3, 2, 1, 1,  8, 1, 0, 0,   0, 1, 0};        // sub reads $3
    tbl[2]  = '{1, 0, 0, 0, 0,  4, 1, 1, 0,   0, 0, 0};        // lw $4
    tbl[3]  = '{1, 9, 4, 1, 1, 11, 1, 0, 0,   1, 0, 0};        // reads $4: load-use
    tbl[4]  = '{1, 9, 4, 1, 1, 11, 1, 0, 0,   0, 0, 2};        // retried
    tbl[5]  = '{1, 0, 0, 0, 0,  5, 1, 0, 0,   0, 0, 0};        // writes $5
    tbl[6]  = '{1, 0, 0, 0, 0,  5, 1, 0, 0,   0, 0, 0};        // writes $5 again
    tbl[7]  = '{1, 5, 5, 1, 1, 10, 0, 0, 0,   0, 1, 1};        // youngest wins
    tbl[8]  = '{1, 0, 0, 0, 0,  0, 1, 0, 0,   0, 0, 0};        // writes $0
    tbl[9]  = '{1, 0, 0, 1, 1, 10, 0, 0, 0,   0, 0, 0};        // reads $0
    tbl[10] = '{1, 0, 0, 0, 0,  7, 1, 0, 0,   0, 0, 0};        // writes $7
    tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0};
    tbl[13] = '{1, 7, 1, 1, 0, 12, 0, 0, 0,   0, WB_CODE, 0};  // $7 only in WB
    tbl[14] = '{1, 0, 0, 0, 0,  6, 1, 1, 0,   0, 0, 0};        // lw $6
    tbl[15] = '{1, 6, 0, 1, 0, 13, 1, 0, 1,   0, 0, 0};        // load-use but flushed
    tbl[16] = '{1, 6, 0, 1, 0, 13, 1, 0, 0,   0, 2, 0};        // load now in MEM

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", ex_sel_a, 0); chk("rst_sel_b", ex_sel_b, 0);
    chk("rst_stall", stall, 0);    chk("rst_bubble", idex_bubble, 0);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i], as, ab, asa, asb, ms, msa, msb);
      chk($sformatf("vec%0d_stall", i), as, tbl[i].e_stall);
      chk($sformatf("vec%0d_bubble", i), ab, tbl[i].e_stall);
      chk($sformatf("vec%0d_sel_a", i), asa, tbl[i].e_sa);
      chk($sformatf("vec%0d_sel_b", i), asb, tbl[i].e_sb);
    end

    // Asynchronous reset while in LU_STALL
    step('{1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0}, as, ab, asa, asb, ms, msa, msb);
    id_valid = 1; id_rs = 5'd0; id_rt = 5'd4; id_rs_used = 0; id_rt_used = 1; id_dst = 5'd9;
    id_reg_write = 1; id_mem_read = 0; branch_flush = 0;
    #1 chk("lu_stall_before_rst", stall, 1);
    @(posedge clk); #1;
    chk("in_lu_stall_state", int'(dut.r_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", stall, 0); chk("arst_bubble", idex_bubble, 0);
    chk("arst_sel_a", ex_sel_a, 0); chk("arst_sel_b", ex_sel_b, 0);
    chk("arst_state_run", int'(dut.r_state), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1 chk("post_rst_no_stall", stall, 0);

    // Random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      vec_t r;
      r.v   = $urandom_range(0, 3) != 0;
      r.rs  = $urandom_range(0, 7);  r.rt  = $urandom_range(0, 7);
      r.rsu = $urandom_range(0, 1);  r.rtu = $urandom_range(0, 1);
      r.dst = $urandom_range(0, 7);
      r.mr  = $urandom_range(0, 2) == 0;
      r.rw  = r.mr || ($urandom_range(0, 3) != 0);
      r.fl  = $urandom_range(0, 9) == 0;
      r.e_stall = 0; r.e_sa = 0; r.e_sb = 0;
      step(r, as, ab, asa, asb, ms, msa, msb);
      chk($sformatf("rnd%0d_stall", k), as, ms);
      chk($sformatf("rnd%0d_bubble", k), ab, ms);
      chk($sformatf("rnd%0d_sel_a", k), asa, msa);
      chk($sformatf("rnd%0d_sel_b", k), asb, msb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1, "timeout");
  end
endmodule
